instr_loader: RTL and testbench
===============================

# instr_loader

Sequential MIPS instruction encoder and instruction-memory loader: accepts symbolic instructions (mnemonic code plus register/immediate fields) over a valid/ready stream, encodes each into a 32-bit MIPS word using the same opcode assignments as the main control decoder, and writes the words to consecutive instruction-memory addresses. It sits between the testbench/boot stimulus and the instruction memory and loads programs that the datapath then fetches and decodes.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load at address 0 (honoured in IDLE and DONE only).
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader accepts fields this cycle.
- in_mnem  in  4  0 R, 1 ANDI, 2 ORI, 3 XORI, 4 ADDI, 5 J, 6 BEQ, 7 BNE, 8 BLEZ, 9 BGTZ, 10 LW, 11 SW, 12 LUI, 13 SLTI, 14–15 invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type function field.
- in_imm  in  26  immediate; [15:0] for I-type, [25:0] for J.
- in_last  in  1  marks the final instruction of the program.
- mem_we  out  1  write request to instruction memory.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- words  out  ADDR_W+1  words written in current load.
- done  out  1  load finished (level, held until next start).
- full  out  1  memory filled to DEPTH words.
- err  out  1  sticky: an invalid mnemonic was received in current load.

## Operation
- FSM: IDLE → (start) LOAD → (last word written, or DEPTH-th word written, or invalid in_last drained) DONE → (start) LOAD. start clears words, err, full, done, address to 0.
- Encoding: R = {000000, rs, rt, rd, 00000, funct}; I = {op, rs, rt, imm[15:0]}; J = {000010, imm[25:0]}. Opcodes: ANDI 001100, ORI 001101, XORI 001110, ADDI 001000, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, LW 100011, SW 101011, LUI 001111, SLTI 001010.
- Field forcing: BLEZ/BGTZ rt forced 0; LUI rs forced 0; all other bits taken verbatim.
- Invalid mnemonic: consumed (handshake completes), err set, no write, address not advanced; if in_last also set, FSM goes DONE once pipeline empty.
- One-entry holding register between encode and memory port; mem_we = hold valid.
- in_ready = LOAD && !last_accepted && (!hold_valid || mem_ready) && (words + hold_valid) < DEPTH.
- Address increments by 1 per completed write (mem_we && mem_ready); words increments likewise.
- full set when words reaches DEPTH; FSM → DONE with done=1 even without in_last; further in_valid ignored.
- start during LOAD ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE; in_ready, mem_we, done, full, err = 0; mem_addr, mem_wdata, words = 0.
- Latency: accept at edge N → mem_we=1 with mem_wdata/mem_addr valid from cycle N+1.
- Throughput: 1 word/cycle while mem_ready held high (accept and write-complete in same cycle allowed).
- Back-pressure: mem_we, mem_addr, mem_wdata stable while mem_we && !mem_ready.
- done rises the cycle after the final write completes; in_ready low in IDLE and DONE.
- Reset mid-load aborts; pending word discarded, no write issued after reset deasserts.

## Structure
- Shared package: mnemonic enumeration, 6-bit opcode constants (identical to decoder values), format field positions.
- Sub-module instr_encode: combinational {mnem, rs, rt, rd, funct, imm} → {word[31:0], valid}; top holds FSM, holding register, counters.

## Test plan
- ADDI rs=0 rt=8 imm=5, in_last=1, mem_ready=1 → addr 0 ← 0x20080005; done=1, words=1.
- R rs=8 rt=9 rd=10 funct=0x20, then J imm=0x10, then BEQ rs=1 rt=2 imm=0xFFFF (last) → 0x01095020, 0x08000010, 0x1022FFFF at addr 0,1,2 in consecutive cycles.
- mem_ready low 3 cycles during first write → mem_wdata/mem_addr stable, in_ready low while second word pending, no word lost or duplicated.
- in_mnem=15 between two valid words → err=1, no mem_we for it, valid words land at addr 0 and 1.
- ADDR_W=2, 5 instructions offered without in_last → 4 written, full=1, done=1, 5th never accepted.
- rst_n asserted with word pending → all outputs 0 immediately; start after release reloads from addr 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the MIPS instruction loader: mnemonic codes, opcode
// constants (same values as the main control decoder) and the symbolic
// instruction payload handed from the stream interface to the encoder.
package instr_loader_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned JIMM_W  = 26;
    localparam int unsigned MNEM_W  = 4;

    // Codes 14 and 15 are deliberately left out: they are the invalid mnemonics.
    typedef enum logic [MNEM_W-1:0] {
        MN_R    = 4'd0,
        MN_ANDI = 4'd1,
        MN_ORI  = 4'd2,
        MN_XORI = 4'd3,
        MN_ADDI = 4'd4,
        MN_J    = 4'd5,
        MN_BEQ  = 4'd6,
        MN_BNE  = 4'd7,
        MN_BLEZ = 4'd8,
        MN_BGTZ = 4'd9,
        MN_LW   = 4'd10,
        MN_SW   = 4'd11,
        MN_LUI  = 4'd12,
        MN_SLTI = 4'd13
    } mnem_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ  = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef struct packed {
        mnem_t               mnem;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [FUNCT_W-1:0]  funct;
        logic [JIMM_W-1:0]   imm;
    } instr_fields_t;

    // I-format word: {op, rs, rt, imm16}.
    function automatic logic [WORD_W-1:0] enc_i(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational MIPS encoder.
//   fields : symbolic instruction (mnemonic, rs, rt, rd, funct, imm)
//   word   : encoded 32-bit instruction
//   valid  : 0 for an unknown mnemonic (word is then 0)
module instr_encode
    import instr_loader_pkg::*;
(
    input  instr_fields_t     fields,
    output logic [WORD_W-1:0] word,
    output logic              valid
);

    logic [IMM_W-1:0] imm16;

    assign imm16 = fields.imm[IMM_W-1:0];

    // BLEZ/BGTZ carry rt=0 and LUI carries rs=0 in the decoder's view.
    always_comb begin
        word  = '0;
        valid = 1'b1;
        case (fields.mnem)
            MN_R:    word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, 5'd0, fields.funct};
            MN_ANDI: word = enc_i(OP_ANDI, fields.rs, fields.rt, imm16);
            MN_ORI:  word = enc_i(OP_ORI,  fields.rs, fields.rt, imm16);
            MN_XORI: word = enc_i(OP_XORI, fields.rs, fields.rt, imm16);
            MN_ADDI: word = enc_i(OP_ADDI, fields.rs, fields.rt, imm16);
            MN_J:    word = {OP_J, fields.imm};
            MN_BEQ:  word = enc_i(OP_BEQ,  fields.rs, fields.rt, imm16);
            MN_BNE:  word = enc_i(OP_BNE,  fields.rs, fields.rt, imm16);
            MN_BLEZ: word = enc_i(OP_BLEZ, fields.rs, 5'd0,      imm16);
            MN_BGTZ: word = enc_i(OP_BGTZ, fields.rs, 5'd0,      imm16);
            MN_LW:   word = enc_i(OP_LW,   fields.rs, fields.rt, imm16);
            MN_SW:   word = enc_i(OP_SW,   fields.rs, fields.rt, imm16);
            MN_LUI:  word = enc_i(OP_LUI,  5'd0,      fields.rt, imm16);
            MN_SLTI: word = enc_i(OP_SLTI, fields.rs, fields.rt, imm16);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts symbolic instructions over valid/ready,
// encodes them and writes them to consecutive word addresses from 0.
//   start                 : begin a load (IDLE/DONE only)
//   in_valid/in_ready     : instruction stream handshake, fields in_mnem..in_imm
//   in_last               : final instruction of the program
//   mem_we/mem_ready      : write handshake, mem_addr/mem_wdata payload
//   words                 : words written in this load
//   done/full/err         : load finished / memory filled / invalid mnemonic seen
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MNEM_W-1:0]   in_mnem,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [FUNCT_W-1:0]  in_funct,
    input  logic [JIMM_W-1:0]   in_imm,
    input  logic                in_last,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic [ADDR_W:0]     words,
    output logic                done,
    output logic                full,
    output logic                err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    instr_fields_t     fields;
    logic [WORD_W-1:0] enc_word;
    logic              enc_valid;
    logic              hold_valid;
    logic              last_accepted;
    logic              accept;
    logic              write_done;
    logic              load_start;
    logic              go_done;
    logic [CNT_W-1:0]  words_inc;
    logic [CNT_W-1:0]  in_flight;

    always_comb begin
        fields.mnem  = mnem_t'(in_mnem);
        fields.rs    = in_rs;
        fields.rt    = in_rt;
        fields.rd    = in_rd;
        fields.funct = in_funct;
        fields.imm   = in_imm;
    end

    instr_encode u_encode (
        .fields (fields),
        .word   (enc_word),
        .valid  (enc_valid)
    );

    assign mem_we     = hold_valid;
    assign write_done = hold_valid && mem_ready;
    assign accept     = in_valid && in_ready;
    assign words_inc  = words + CNT_W'(1);
    // Words already written plus the one waiting in the holding register.
    assign in_flight  = words + CNT_W'(hold_valid);

    assign in_ready = (state == ST_LOAD) && !last_accepted
                   && (!hold_valid || mem_ready)
                   && (in_flight < CNT_W'(DEPTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state: leave LOAD once the pipeline drains after the last
    // instruction, or on the write that fills the memory.
    always_comb begin
        state_next = state;
        load_start = 1'b0;
        go_done    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            ST_LOAD: begin
                if ((last_accepted && (!hold_valid || mem_ready))
                    || (write_done && (words_inc == CNT_W'(DEPTH)))) begin
                    state_next = ST_DONE;
                    go_done    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Holding register, address/word counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid    <= 1'b0;
            mem_wdata     <= '0;
            mem_addr      <= '0;
            words         <= '0;
            done          <= 1'b0;
            full          <= 1'b0;
            err           <= 1'b0;
            last_accepted <= 1'b0;
        end else if (load_start) begin
            hold_valid    <= 1'b0;
            mem_wdata     <= '0;
            mem_addr      <= '0;
            words         <= '0;
            done          <= 1'b0;
            full          <= 1'b0;
            err           <= 1'b0;
            last_accepted <= 1'b0;
        end else begin
            if (write_done) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                words    <= words_inc;
                if (words_inc == CNT_W'(DEPTH)) full <= 1'b1;
            end
            // A new word may replace the one completing this same cycle.
            if (accept && enc_valid) begin
                hold_valid <= 1'b1;
                mem_wdata  <= enc_word;
            end else if (write_done) begin
                hold_valid <= 1'b0;
            end
            if (accept && !enc_valid) err <= 1'b1;
            if (accept && in_last)    last_accepted <= 1'b1;
            if (go_done)              done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-size instance (ADDR_W=8) and a
// four-word instance (ADDR_W=2) share the instruction stream; each has its
// own start and its own write log.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_mnem = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [5:0]  in_funct = '0;
    logic [25:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_ready = 1'b1;

    logic        in_ready, mem_we, done, full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words;

    logic        in_ready_s, mem_we_s, done_s, full_s, err_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  words_s;

    int nvec = 0;
    int nerr = 0;

    instr_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .words(words), .done(done), .full(full), .err(err)
    );

    instr_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_s), .mem_ready(mem_ready), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .words(words_s), .done(done_s), .full(full_s),
        .err(err_s)
    );

    always #5 clk = ~clk;

    // Write logs: one entry per completed write (mem_we && mem_ready).
    int          cyc = 0;
    int          wcnt = 0, wcnt_s = 0;
    logic [31:0] wlog_d [64];
    logic [7:0]  wlog_a [64];
    int          wlog_c [64];
    logic [31:0] wlog_d_s [64];
    logic [1:0]  wlog_a_s [64];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && mem_we && mem_ready && wcnt < 64) begin
            wlog_d[wcnt] = mem_wdata;
            wlog_a[wcnt] = mem_addr;
            wlog_c[wcnt] = cyc;
            wcnt = wcnt + 1;
        end
        if (rst_n && mem_we_s && mem_ready && wcnt_s < 64) begin
            wlog_d_s[wcnt_s] = mem_wdata_s;
            wlog_a_s[wcnt_s] = mem_addr_s;
            wcnt_s = wcnt_s + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    // Offer one instruction for up to 'budget' cycles; ok=1 once accepted.
    task automatic send(input bit sel, input logic [3:0] mn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                        input logic [25:0] imm, input logic last, input int budget,
                        output bit ok);
        logic r;
        in_valid = 1'b1;
        in_mnem  = mn;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_funct = fn;
        in_imm   = imm;
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            r = sel ? in_ready_s : in_ready;
            @(posedge clk);
            if (r) ok = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sel ? done_s : done) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int b;

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_words",    32'(words),    32'd0);
        check("rst_wdata",    mem_wdata,     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Single ADDI with in_last
        b = wcnt;
        pulse_start(1'b0);
        send(1'b0, 4'd4, 5'd0, 5'd8, 5'd0, 6'd0, 26'h5, 1'b1, 20, ok);
        check("t1_acc", 32'(ok), 32'd1);
        wait_done(1'b0, ok);
        check("t1_done_seen", 32'(ok), 32'd1);
        check("t1_nwr",  32'(wcnt - b), 32'd1);
        check("t1_addr", 32'(wlog_a[b]), 32'd0);
        check("t1_data", wlog_d[b], 32'h2008_0005);
        check("t1_words", 32'(words), 32'd1);
        check("t1_ready_done", 32'(in_ready), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // R, J, BEQ back to back
        b = wcnt;
        pulse_start(1'b0);
        send(1'b0, 4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 26'h0, 1'b0, 20, ok);
        check("t2_acc0", 32'(ok), 32'd1);
        send(1'b0, 4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 26'h10, 1'b0, 20, ok);
        check("t2_acc1", 32'(ok), 32'd1);
        send(1'b0, 4'd6, 5'd1, 5'd2, 5'd0, 6'd0, 26'hFFFF, 1'b1, 20, ok);
        check("t2_acc2", 32'(ok), 32'd1);
        wait_done(1'b0, ok);
        check("t2_done_seen", 32'(ok), 32'd1);
        check("t2_nwr", 32'(wcnt - b), 32'd3);
        check("t2_d0", wlog_d[b],   32'h0109_5020);
        check("t2_d1", wlog_d[b+1], 32'h0800_0010);
        check("t2_d2", wlog_d[b+2], 32'h1022_FFFF);
        check("t2_a0", 32'(wlog_a[b]),   32'd0);
        check("t2_a1", 32'(wlog_a[b+1]), 32'd1);
        check("t2_a2", 32'(wlog_a[b+2]), 32'd2);
        check("t2_gap1", 32'(wlog_c[b+1] - wlog_c[b]),   32'd1);
        check("t2_gap2", 32'(wlog_c[b+2] - wlog_c[b+1]), 32'd1);
        check("t2_words", 32'(words), 32'd3);

        // Back-pressure: ORI held while mem_ready low, then LUI (rs forced 0)
        b = wcnt;
        mem_ready = 1'b0;
        pulse_start(1'b0);
        send(1'b0, 4'd2, 5'd3, 5'd4, 5'd0, 6'd0, 26'h1234, 1'b0, 20, ok);
        check("t3_accA", 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_mnem  = 4'd12;
        in_rs    = 5'd7;
        in_rt    = 5'd5;
        in_imm   = 26'hABCD;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_we",    32'(mem_we),   32'd1);
            check("t3_stall_addr",  32'(mem_addr), 32'd0);
            check("t3_stall_data",  mem_wdata,     32'h3464_1234);
            check("t3_stall_ready", 32'(in_ready), 32'd0);
        end
        check("t3_stall_nwr", 32'(wcnt - b), 32'd0);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        send(1'b0, 4'd12, 5'd7, 5'd5, 5'd0, 6'd0, 26'hABCD, 1'b1, 20, ok);
        check("t3_accB", 32'(ok), 32'd1);
        wait_done(1'b0, ok);
        check("t3_done_seen", 32'(ok), 32'd1);
        check("t3_nwr", 32'(wcnt - b), 32'd2);
        check("t3_d0", wlog_d[b],   32'h3464_1234);
        check("t3_d1", wlog_d[b+1], 32'h3C05_ABCD);
        check("t3_a1", 32'(wlog_a[b+1]), 32'd1);

        // Invalid mnemonic between SW and BLEZ (rt forced 0)
        b = wcnt;
        pulse_start(1'b0);
        send(1'b0, 4'd11, 5'd29, 5'd31, 5'd0, 6'd0, 26'h8, 1'b0, 20, ok);
        send(1'b0, 4'd15, 5'd1, 5'd1, 5'd1, 6'd1, 26'h1, 1'b0, 20, ok);
        check("t4_acc_bad", 32'(ok), 32'd1);
        send(1'b0, 4'd8, 5'd6, 5'd9, 5'd0, 6'd0, 26'h3, 1'b1, 20, ok);
        wait_done(1'b0, ok);
        check("t4_done_seen", 32'(ok), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_nwr", 32'(wcnt - b), 32'd2);
        check("t4_d0", wlog_d[b],   32'hAFBF_0008);
        check("t4_d1", wlog_d[b+1], 32'h18C0_0003);
        check("t4_a1", 32'(wlog_a[b+1]), 32'd1);
        check("t4_words", 32'(words), 32'd2);

        // Invalid mnemonic carrying in_last ends the load with nothing written
        b = wcnt;
        pulse_start(1'b0);
        check("t4b_err_clr", 32'(err), 32'd0);
        send(1'b0, 4'd14, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0, 1'b1, 20, ok);
        wait_done(1'b0, ok);
        check("t4b_done_seen", 32'(ok), 32'd1);
        check("t4b_err", 32'(err), 32'd1);
        check("t4b_words", 32'(words), 32'd0);
        check("t4b_nwr", 32'(wcnt - b), 32'd0);

        // Four-word memory: fifth instruction never accepted
        b = wcnt_s;
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 26'(i), 1'b0, 20, ok);
            check("t5_acc", 32'(ok), 32'd1);
        end
        send(1'b1, 4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 26'd4, 1'b0, 10, ok);
        check("t5_acc5", 32'(ok), 32'd0);
        check("t5_nwr", 32'(wcnt_s - b), 32'd4);
        check("t5_full", 32'(full_s), 32'd1);
        check("t5_done", 32'(done_s), 32'd1);
        check("t5_words", 32'(words_s), 32'd4);
        check("t5_d3", wlog_d_s[b+3], 32'h2001_0003);
        check("t5_a3", 32'(wlog_a_s[b+3]), 32'd3);

        // Reset with a word pending, then reload
        mem_ready = 1'b0;
        pulse_start(1'b0);
        send(1'b0, 4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 26'h7, 1'b0, 20, ok);
        check("t6_pending", 32'(mem_we), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_we",    32'(mem_we),   32'd0);
        check("t6_data",  mem_wdata,     32'd0);
        check("t6_words", 32'(words),    32'd0);
        check("t6_done",  32'(done),     32'd0);
        check("t6_err",   32'(err),      32'd0);
        check("t6_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        b = wcnt;
        repeat (4) @(negedge clk);
        check("t6_no_wr", 32'(wcnt - b), 32'd0);
        @(posedge clk);
        #1;
        pulse_start(1'b0);
        send(1'b0, 4'd3, 5'd2, 5'd3, 5'd0, 6'd0, 26'h00FF, 1'b1, 20, ok);
        wait_done(1'b0, ok);
        check("t6_done_seen", 32'(ok), 32'd1);
        check("t6_nwr", 32'(wcnt - b), 32'd1);
        check("t6_addr", 32'(wlog_a[b]), 32'd0);
        check("t6_reload", wlog_d[b], 32'h3843_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
